// File: rtl/clk_ctrl_pkg.sv
// Shared types and helpers for clock-control blocks: FSM state encoding,
// statistics width and a constant-safe clog2.
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        ACK    = 2'd2,
        DWELL  = 2'd3
    } state_t;

    localparam int SW_COUNT_W = 16;

    // Smallest r with 2**r >= v; returns 0 for v <= 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: first set request at or above ptr, with wrap.
module rr_arb
    import clk_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = (clog2(NREQ) < 1) ? 1 : clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            any
);

    always_comb begin
        int j;
        any   = 1'b0;
        idx   = '0;
        grant = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = IW'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_switch_sched.sv
// Arbitrates clock-source requests onto the glitch-free mux select, holds
// off the acknowledge until the mux handover window has elapsed.
module clk_switch_sched
    import clk_ctrl_pkg::*;
#(
    parameter int NREQ          = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int DWELL_CYCLES  = 8,
    parameter int DEFAULT_SRC   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       req_src,
    output logic [NREQ-1:0]       gnt,
    output logic                  sel,
    output logic                  cur_src,
    output logic                  busy,
    output logic [SW_COUNT_W-1:0] sw_count,
    output logic [1:0]            dbg_state
);

    localparam int IW  = (clog2(NREQ) < 1) ? 1 : clog2(NREQ);
    localparam int MAXC = (SETTLE_CYCLES > DWELL_CYCLES) ? SETTLE_CYCLES : DWELL_CYCLES;
    localparam int CW  = (clog2(MAXC + 1) < 1) ? 1 : clog2(MAXC + 1);
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] DWELL_LOAD  = (DWELL_CYCLES > 0) ? CW'(DWELL_CYCLES - 1) : '0;
    localparam logic          RST_SRC     = 1'(DEFAULT_SRC);

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic                  sel_n, cur_n;
    logic [IW-1:0]         k, k_n, ptr, ptr_n;
    logic [NREQ-1:0]       k_oh, k_oh_n;
    logic                  switched, switched_n;
    logic [SW_COUNT_W-1:0] sw_count_n;

    logic [NREQ-1:0]       arb_grant;
    logic [IW-1:0]         arb_idx;
    logic                  arb_any;

    rr_arb #(.NREQ(NREQ), .IW(IW)) u_arb (
        .req   (req),
        .ptr   (ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sel      <= RST_SRC;
            cur_src  <= RST_SRC;
            k        <= '0;
            k_oh     <= '0;
            ptr      <= '0;
            switched <= 1'b0;
            sw_count <= '0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            sel      <= sel_n;
            cur_src  <= cur_n;
            k        <= k_n;
            k_oh     <= k_oh_n;
            ptr      <= ptr_n;
            switched <= switched_n;
            sw_count <= sw_count_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        sel_n      = sel;
        cur_n      = cur_src;
        k_n        = k;
        k_oh_n     = k_oh;
        ptr_n      = ptr;
        switched_n = switched;
        sw_count_n = sw_count;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    k_n    = arb_idx;
                    k_oh_n = arb_grant;
                    if (req_src[arb_idx] == cur_src) begin
                        switched_n = 1'b0;
                        state_n    = ACK;
                    end else begin
                        switched_n = 1'b1;
                        sel_n      = req_src[arb_idx];
                        cnt_n      = SETTLE_LOAD;
                        state_n    = SETTLE;
                    end
                end
            end
            // sel is frozen here: a started handover always runs to completion.
            SETTLE: begin
                if (cnt == '0) begin
                    cur_n = sel;
                    if (sw_count != '1) sw_count_n = sw_count + 1'b1;
                    state_n = ACK;
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end
            ACK: begin
                ptr_n = (int'(k) == NREQ - 1) ? '0 : k + 1'b1;
                if (switched && (DWELL_CYCLES > 0)) begin
                    cnt_n   = DWELL_LOAD;
                    state_n = DWELL;
                end else begin
                    state_n = IDLE;
                end
            end
            DWELL: begin
                if (cnt == '0) state_n = IDLE;
                else           cnt_n   = cnt - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign gnt       = (state == ACK) ? k_oh : '0;
    assign busy      = (state == SETTLE) || (state == DWELL);
    assign dbg_state = state;

endmodule
